// File: rtl/traffic_light_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared state encoding, lamp vectors and default dwell times
//               for the two-road traffic light controller.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  typedef enum logic [1:0] {
    S_NS_GREEN  = 2'd0,
    S_NS_YELLOW = 2'd1,
    S_EW_GREEN  = 2'd2,
    S_EW_YELLOW = 2'd3
  } state_t;

  // Lamp vectors are {red, yellow, green}.
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam int unsigned c_DEF_NS_GREEN_TICKS = 32;
  localparam int unsigned c_DEF_EW_GREEN_TICKS = 16;
  localparam int unsigned c_DEF_YELLOW_TICKS   = 4;

  localparam int unsigned c_NS_COUNT_W = 5;
  localparam int unsigned c_EW_COUNT_W = 4;
  localparam int unsigned c_Y_COUNT_W  = 2;

  // NS lamp pattern for a given state.
  function automatic logic [2:0] ns_lamp(input state_t s);
    case (s)
      S_NS_GREEN:  ns_lamp = LAMP_GREEN;
      S_NS_YELLOW: ns_lamp = LAMP_YELLOW;
      default:     ns_lamp = LAMP_RED;
    endcase
  endfunction

  // EW lamp pattern for a given state.
  function automatic logic [2:0] ew_lamp(input state_t s);
    case (s)
      S_EW_GREEN:  ew_lamp = LAMP_GREEN;
      S_EW_YELLOW: ew_lamp = LAMP_YELLOW;
      default:     ew_lamp = LAMP_RED;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_controller_dwell_counter.sv
`default_nettype none
// ============================================================================
// Module      : dwell_counter
// Description : Tick-driven up-counter that saturates at TERMINAL and flags
//               when the terminal value has been reached.
// Revision    : 1.0 - initial release
// ============================================================================
module dwell_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TERMINAL = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  localparam logic [WIDTH-1:0] c_TERM = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] r_count;

  // Count ticks up to the terminal value; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (tick && (r_count != c_TERM)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;
  assign done  = (r_count == c_TERM);

endmodule
`default_nettype wire

// File: rtl/traffic_light_controller.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_controller
// Description : Two-road intersection controller. NS rests on green and
//               yields to EW only on demand; EW green and both yellows run
//               for fixed dwell times. Lamps are registered from next-state.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_controller
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 1,
  parameter int unsigned NS_GREEN_TICKS = c_DEF_NS_GREEN_TICKS,
  parameter int unsigned EW_GREEN_TICKS = c_DEF_EW_GREEN_TICKS,
  parameter int unsigned YELLOW_TICKS   = c_DEF_YELLOW_TICKS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ns_vehicle_detect,
  input  logic                    ew_vehicle_detect,
  output logic                    ns_red,
  output logic                    ns_yellow,
  output logic                    ns_green,
  output logic                    ew_red,
  output logic                    ew_yellow,
  output logic                    ew_green,
  output logic [c_NS_COUNT_W-1:0] ns_count,
  output logic [c_EW_COUNT_W-1:0] ew_count,
  output logic [c_Y_COUNT_W-1:0]  y_count
);

  localparam int unsigned c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [c_TICK_W-1:0] r_tick_cnt;
  logic                w_tick;

  state_t r_state;
  state_t w_next;

  logic w_ns_done;
  logic w_ew_done;
  logic w_y_done;
  logic w_ns_clear;
  logic w_ew_clear;
  logic w_y_clear;

  logic [2:0] r_ns_lamp;
  logic [2:0] r_ew_lamp;

  // NS is the default-green road, so its own demand never changes anything.
  logic w_unused_ns_detect;
  assign w_unused_ns_detect = ns_vehicle_detect;

  assign w_tick = (r_tick_cnt == c_TICK_W'(TICK_DIV - 1));

  // Tick prescaler: one tick every TICK_DIV clocks.
  always_ff @(posedge clk) begin
    if (rst || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_NS_GREEN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; demand is only looked at on the leaving tick.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_NS_GREEN: begin
        if (w_tick && w_ns_done && ew_vehicle_detect) begin
          w_next = S_NS_YELLOW;
        end
      end
      S_NS_YELLOW: begin
        if (w_tick && w_y_done) begin
          w_next = S_EW_GREEN;
        end
      end
      S_EW_GREEN: begin
        if (w_tick && w_ew_done) begin
          w_next = S_EW_YELLOW;
        end
      end
      S_EW_YELLOW: begin
        if (w_tick && w_y_done) begin
          w_next = S_NS_GREEN;
        end
      end
      default: w_next = S_NS_GREEN;
    endcase
  end

  // A counter is held at zero while its state is not active, and is cleared
  // on every state change so each entry starts from zero.
  assign w_ns_clear = (r_state != w_next) || (r_state != S_NS_GREEN);
  assign w_ew_clear = (r_state != w_next) || (r_state != S_EW_GREEN);
  assign w_y_clear  = (r_state != w_next) ||
                      ((r_state != S_NS_YELLOW) && (r_state != S_EW_YELLOW));

  dwell_counter #(
    .WIDTH    (c_NS_COUNT_W),
    .TERMINAL (NS_GREEN_TICKS - 1)
  ) u_ns_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (w_ns_clear),
    .tick  (w_tick),
    .count (ns_count),
    .done  (w_ns_done)
  );

  dwell_counter #(
    .WIDTH    (c_EW_COUNT_W),
    .TERMINAL (EW_GREEN_TICKS - 1)
  ) u_ew_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (w_ew_clear),
    .tick  (w_tick),
    .count (ew_count),
    .done  (w_ew_done)
  );

  dwell_counter #(
    .WIDTH    (c_Y_COUNT_W),
    .TERMINAL (YELLOW_TICKS - 1)
  ) u_y_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (w_y_clear),
    .tick  (w_tick),
    .count (y_count),
    .done  (w_y_done)
  );

  // Lamps registered from next-state so they switch on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ns_lamp <= LAMP_GREEN;
      r_ew_lamp <= LAMP_RED;
    end else begin
      r_ns_lamp <= ns_lamp(w_next);
      r_ew_lamp <= ew_lamp(w_next);
    end
  end

  assign {ns_red, ns_yellow, ns_green} = r_ns_lamp;
  assign {ew_red, ew_yellow, ew_green} = r_ew_lamp;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_controller
// Description : Directed self-checking bench for traffic_light_controller.
//               Cycle k is sampled on the falling edge before the k-th
//               rising edge after reset is released.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_controller;

  logic       clk;
  logic       rst;
  logic       ns_det;
  logic       ew_det;
  logic       ns_red, ns_yellow, ns_green;
  logic       ew_red, ew_yellow, ew_green;
  logic [4:0] ns_count;
  logic [3:0] ew_count;
  logic [1:0] y_count;

  int n_checks;
  int n_fail;

  traffic_light_controller dut (
    .clk               (clk),
    .rst               (rst),
    .ns_vehicle_detect (ns_det),
    .ew_vehicle_detect (ew_det),
    .ns_red            (ns_red),
    .ns_yellow         (ns_yellow),
    .ns_green          (ns_green),
    .ew_red            (ew_red),
    .ew_yellow         (ew_yellow),
    .ew_green          (ew_green),
    .ns_count          (ns_count),
    .ew_count          (ew_count),
    .y_count           (y_count)
  );

  // {ns_r,ns_y,ns_g, ew_r,ew_y,ew_g, ns_count, ew_count, y_count}
  logic [16:0] obs;
  assign obs = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
                ns_count, ew_count, y_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected observation vector for state st (0..3) with its own counter at c.
  function automatic logic [16:0] mk(input int st, input int c);
    logic [5:0] lamps;
    logic [4:0] nsc;
    logic [3:0] ewc;
    logic [1:0] yc;
    nsc = '0;
    ewc = '0;
    yc  = '0;
    case (st)
      0:       begin lamps = 6'b001_100; nsc = 5'(c); end
      1:       begin lamps = 6'b010_100; yc  = 2'(c); end
      2:       begin lamps = 6'b100_001; ewc = 4'(c); end
      default: begin lamps = 6'b100_010; yc  = 2'(c); end
    endcase
    return {lamps, nsc, ewc, yc};
  endfunction

  // Expected vector at cycle k under continuous EW demand (56-cycle period).
  function automatic logic [16:0] sched(input int k);
    int m;
    m = k % 56;
    if (m < 32)      return mk(0, m);
    else if (m < 36) return mk(1, m - 32);
    else if (m < 52) return mk(2, m - 36);
    else             return mk(3, m - 52);
  endfunction

  // Hold rst for n edges, release it, and land on the sample point of cycle 0.
  task automatic apply_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    ns_det = 1'b0;
    ew_det = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== mk(0, 0)) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %b want %b", i, obs, mk(0, 0));
      end
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== mk(0, 0)) begin
      n_fail++;
      $display("FAIL reset_cycle0: got %b want %b", obs, mk(0, 0));
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (obs !== mk(0, 1)) begin
      n_fail++;
      $display("FAIL reset_cycle1: got %b want %b", obs, mk(0, 1));
    end
  endtask

  task automatic test_full_cycle();
    ew_det = 1'b1;
    apply_reset(2);
    for (int k = 0; k <= 112; k++) begin
      n_checks++;
      if (obs !== sched(k)) begin
        n_fail++;
        $display("FAIL full_cycle[%0d]: got %b want %b", k, obs, sched(k));
      end
      @(posedge clk); #1;
      @(negedge clk);
    end
  endtask

  task automatic test_hold_green();
    ew_det = 1'b0;
    apply_reset(2);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
    end
    // now at cycle 100; demand still low
    n_checks++;
    if (obs !== mk(0, 31)) begin
      n_fail++;
      $display("FAIL hold_saturate: got %b want %b", obs, mk(0, 31));
    end
    @(posedge clk); #1;
    ew_det = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== mk(0, 31)) begin
      n_fail++;
      $display("FAIL hold_demand_cycle: got %b want %b", obs, mk(0, 31));
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (obs !== mk(1, 0)) begin
      n_fail++;
      $display("FAIL hold_to_yellow: got %b want %b", obs, mk(1, 0));
    end
  endtask

  task automatic test_ew_drop();
    ew_det = 1'b1;
    apply_reset(2);
    for (int k = 0; k <= 70; k++) begin
      n_checks++;
      if (obs !== sched(k > 56 ? 56 + (k - 56) : k)) begin
        n_fail++;
        $display("FAIL ew_drop[%0d]: got %b want %b", k, obs, sched(k));
      end
      @(posedge clk); #1;
      if (k == 39) ew_det = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_pulse();
    ew_det = 1'b1;
    apply_reset(2);
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); #1;
      if (k == 44) rst = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (obs !== mk(2, 9)) begin
      n_fail++;
      $display("FAIL pulse_before: got %b want %b", obs, mk(2, 9));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== mk(0, 0)) begin
      n_fail++;
      $display("FAIL pulse_reset_state: got %b want %b", obs, mk(0, 0));
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (obs !== mk(0, 1)) begin
      n_fail++;
      $display("FAIL pulse_after: got %b want %b", obs, mk(0, 1));
    end
  endtask

  task automatic test_random();
    int run;
    run    = 0;
    ew_det = 1'b0;
    ns_det = 1'b0;
    apply_reset(2);
    for (int k = 0; k < 1000; k++) begin
      n_checks++;
      if (!$onehot({ns_red, ns_yellow, ns_green}) ||
          !$onehot({ew_red, ew_yellow, ew_green})) begin
        n_fail++;
        $display("FAIL rand_onehot[%0d]: got ns=%b ew=%b want one-hot each", k,
                 {ns_red, ns_yellow, ns_green}, {ew_red, ew_yellow, ew_green});
      end
      n_checks++;
      if (!ns_red && !ew_red) begin
        n_fail++;
        $display("FAIL rand_conflict[%0d]: got ns_red=%b ew_red=%b want one red",
                 k, ns_red, ew_red);
      end
      if (ns_green) begin
        run++;
      end else if (run > 0) begin
        n_checks++;
        if (run < 32) begin
          n_fail++;
          $display("FAIL rand_ns_min_green[%0d]: got %0d cycles want >=32", k, run);
        end
        run = 0;
      end
      @(posedge clk); #1;
      if ((k % 21) == 20) ew_det = 1'($urandom_range(0, 1));
      ns_det = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    ns_det   = 1'b0;
    ew_det   = 1'b0;
    test_reset();
    test_full_cycle();
    test_hold_green();
    test_ew_drop();
    test_reset_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
